// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, dual-read-port instruction cache.
// Serves two fetch lookups per cycle and refills one line at a time, word by
// word, from the next memory level. Read-only: no write path, no dirty state.
// Optional feature macro: ICACHE_STATS_EN adds hit_count / miss_count outputs.
module instr_cache #(
  parameter int XLEN           = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [1:0]      read,
  input  logic [XLEN-1:0] req_address [2],
  output logic [1:0]      hit,
  output logic [31:0]     data [2],
  output logic [XLEN-1:0] address [2],
  output logic            mem_read,
  output logic [XLEN-1:0] mem_address,
  input  logic [31:0]     mem_data,
  input  logic            mem_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int WB  = $clog2(WORDS_PER_LINE);
  localparam int IB  = $clog2(LINES);
  localparam int OFF = WB + 2;
  localparam int LW  = XLEN - OFF;      // line-number width (index + tag)
  localparam int TW  = LW - IB;         // tag width

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
  logic [TW-1:0]    tag_mem  [LINES];
  logic [LINES-1:0] valid_reg;
  logic [0:0]       state_reg;
  logic [WB-1:0]    beat_reg;
  logic [LW-1:0]    line_reg;           // line number being refilled

  logic [LW-1:0]    req_line  [2];
  logic [IB-1:0]    req_idx   [2];
  logic [TW-1:0]    req_tag   [2];
  logic [WB-1:0]    req_word  [2];
  logic [31:0]      word_data [2];
  logic [1:0]       lookup_hit;
  logic [1:0]       miss;
  logic [1:0]       hit_next;
  logic             beat_done;
  logic             last_beat;
  logic             start_refill;
  logic [3:0]       unused_addr_bits;

  // Byte-offset bits of the fetch address carry no information for word fetches.
  assign unused_addr_bits = {req_address[1][1:0], req_address[0][1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req_line[gi]   = req_address[gi][XLEN-1:OFF];
      assign req_idx[gi]    = req_line[gi][IB-1:0];
      assign req_tag[gi]    = req_line[gi][LW-1:IB];
      assign req_word[gi]   = req_address[gi][OFF-1:2];
      assign word_data[gi]  = data_mem[{req_idx[gi], req_word[gi]}];
      assign lookup_hit[gi] = read[gi] && valid_reg[req_idx[gi]]
                              && (tag_mem[req_idx[gi]] == req_tag[gi]);
      assign miss[gi]       = read[gi] && !lookup_hit[gi];
      // Lookups are only honoured while idle and never on a flush edge.
      assign hit_next[gi]   = (state_reg == IDLE) && !flush && lookup_hit[gi];

      // Per-port registered word and address echo; they hold when not hitting.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          data[gi]    <= '0;
          address[gi] <= '0;
        end else if (hit_next[gi]) begin
          data[gi]    <= word_data[gi];
          address[gi] <= req_address[gi];
        end
      end
    end
  endgenerate

  assign beat_done    = (state_reg == REFILL) && mem_ready;
  assign last_beat    = beat_done && (beat_reg == WB'(WORDS_PER_LINE - 1));
  assign start_refill = (state_reg == IDLE) && !flush && (|miss);
  assign mem_read     = (state_reg == REFILL);
  assign mem_address  = {line_reg, beat_reg, 2'b00};

  // Data and tag storage: written by refill beats, never reset (valid bits gate use).
  always_ff @(posedge clock) begin
    if (beat_done) begin
      data_mem[{line_reg[IB-1:0], beat_reg}] <= mem_data;
    end
    if (last_beat) begin
      tag_mem[line_reg[IB-1:0]] <= line_reg[LW-1:IB];
    end
  end

  // Hit flags: one-cycle registered lookup result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit <= 2'b00;
    end else begin
      hit <= hit_next;
    end
  end

  // Refill control; flush overrides everything, including a final beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      line_reg  <= '0;
      valid_reg <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      valid_reg <= '0;
    end else if (start_refill) begin
      // Port 0 wins; a port-1 miss on the same line is covered by this refill.
      state_reg <= REFILL;
      beat_reg  <= '0;
      line_reg  <= miss[0] ? req_line[0] : req_line[1];
    end else if (beat_done) begin
      beat_reg <= beat_reg + WB'(1);
      if (last_beat) begin
        valid_reg[line_reg[IB-1:0]] <= 1'b1;
        state_reg                   <= IDLE;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Statistics: hits per edge (0..2) and refills started; cleared by flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= hit_count + 32'(hit_next[0]) + 32'(hit_next[1]);
      miss_count <= miss_count + 32'(start_refill);
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed scenarios plus randomized fetches checked against a
// line-residency model of a 16-line, 4-word direct-mapped cache.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  read = 2'b00;
  logic [31:0] req_address [2];
  logic [1:0]  hit;
  logic [31:0] data [2];
  logic [31:0] address [2];
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_ready = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;
  int rand_mode = 0;
  int ready_pct = 100;
  logic [31:0] beat_q [$];

  instr_cache dut (
    .clock(clk), .reset(reset), .flush(flush), .read(read),
    .req_address(req_address), .hit(hit), .data(data), .address(address),
    .mem_read(mem_read), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ready(mem_ready)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Backing memory content: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign mem_data = mem_word(mem_address);

  // Record every refill beat that will complete on the coming rising edge.
  always @(negedge clk) begin
    if (reset && !flush && mem_read && mem_ready) beat_q.push_back(mem_address);
  end

  task automatic step;
    @(posedge clk);
    #1;
    if (rand_mode != 0) mem_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic wait_refill_done(input string name);
    int n = 0;
    while (mem_read && n < 60) begin
      step;
      n++;
    end
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: mem_read still %b after %0d cycles, want 0", name, mem_read, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; read = 2'b00; flush = 1'b0; mem_ready = 1'b0;
    req_address[0] = '0; req_address[1] = '0;
    step; step;
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL reset_hit: got %b want 00", hit); end
    checks++; if (data[0] !== 32'h0 || data[1] !== 32'h0) begin errors++; $display("FAIL reset_data: got %h %h want 0 0", data[0], data[1]); end
    checks++; if (address[0] !== 32'h0 || address[1] !== 32'h0) begin errors++; $display("FAIL reset_address: got %h %h want 0 0", address[0], address[1]); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
    reset = 1'b1;
    step;
    $display("reset: done");
  endtask

  task automatic test_cold_miss;
    beat_q.delete();
    req_address[0] = 32'h100; read = 2'b01; mem_ready = 1'b0;
    step;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL cold_mem_read: got %b want 1", mem_read); end
    checks++; if (mem_address !== 32'h100) begin errors++; $display("FAIL cold_addr0: got %h want 100", mem_address); end
    mem_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step;
      checks++; if (mem_address !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL cold_addr%0d: got %h want %h", k, mem_address, 32'h100 + 32'(4 * k)); end
      checks++; if (hit !== 2'b00) begin errors++; $display("FAIL cold_hit_in_refill: got %b want 00", hit); end
    end
    step;
    mem_ready = 1'b0;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL cold_mem_read_end: got %b want 0", mem_read); end
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL cold_hit_end: got %b want 00", hit); end
    step;
    checks++; if (hit[0] !== 1'b1) begin errors++; $display("FAIL cold_hit: got %b want 1", hit[0]); end
    checks++; if (data[0] !== mem_word(32'h100)) begin errors++; $display("FAIL cold_data: got %h want %h", data[0], mem_word(32'h100)); end
    checks++; if (address[0] !== 32'h100) begin errors++; $display("FAIL cold_address: got %h want 100", address[0]); end
    checks++; if (beat_q.size() != 4) begin errors++; $display("FAIL cold_beats: got %0d want 4", beat_q.size()); end
    read = 2'b00;
    step;
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL cold_idle_hit: got %b want 00", hit); end
    checks++; if (data[0] !== mem_word(32'h100)) begin errors++; $display("FAIL cold_hold: got %h want %h", data[0], mem_word(32'h100)); end
    $display("cold_miss: @100 refilled and hit");
  endtask

  task automatic test_dual_hit;
    req_address[0] = 32'h104; req_address[1] = 32'h108; read = 2'b11;
    step;
    checks++; if (hit !== 2'b11) begin errors++; $display("FAIL dual_hit: got %b want 11", hit); end
    checks++; if (data[0] !== mem_word(32'h104)) begin errors++; $display("FAIL dual_data0: got %h want %h", data[0], mem_word(32'h104)); end
    checks++; if (data[1] !== mem_word(32'h108)) begin errors++; $display("FAIL dual_data1: got %h want %h", data[1], mem_word(32'h108)); end
    checks++; if (address[1] !== 32'h108) begin errors++; $display("FAIL dual_address1: got %h want 108", address[1]); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL dual_mem_read: got %b want 0", mem_read); end
    read = 2'b00;
    step;
    $display("dual_hit: @104/@108");
  endtask

  task automatic test_split;
    beat_q.delete();
    req_address[0] = 32'h10C; req_address[1] = 32'h110; read = 2'b11;
    step;
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h110) begin errors++; $display("FAIL split_start: got %b/%h want 1/110", mem_read, mem_address); end
    mem_ready = 1'b1;
    wait_refill_done("split");
    mem_ready = 1'b0;
    step;
    checks++; if (hit !== 2'b11) begin errors++; $display("FAIL split_hit: got %b want 11", hit); end
    checks++; if (data[0] !== mem_word(32'h10C)) begin errors++; $display("FAIL split_data0: got %h want %h", data[0], mem_word(32'h10C)); end
    checks++; if (data[1] !== mem_word(32'h110)) begin errors++; $display("FAIL split_data1: got %h want %h", data[1], mem_word(32'h110)); end
    checks++; if (beat_q.size() != 4 || beat_q[0] !== 32'h110) begin errors++; $display("FAIL split_beats: got %0d beats want 4 from 110", beat_q.size()); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL split_one_refill: got %b want 0", mem_read); end
    read = 2'b00;
    step;
    $display("split: @10C/@110");
  endtask

  task automatic test_stall;
    req_address[0] = 32'h200; read = 2'b01;
    step;
    mem_ready = 1'b1;
    step; step;
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step;
      checks++; if (mem_address !== 32'h208 || mem_read !== 1'b1) begin errors++; $display("FAIL stall_addr%0d: got %b/%h want 1/208", k, mem_read, mem_address); end
      checks++; if (hit !== 2'b00) begin errors++; $display("FAIL stall_hit%0d: got %b want 00", k, hit); end
    end
    mem_ready = 1'b1;
    wait_refill_done("stall");
    mem_ready = 1'b0;
    step;
    checks++; if (hit[0] !== 1'b1 || data[0] !== mem_word(32'h200)) begin errors++; $display("FAIL stall_hit: got %b/%h want 1/%h", hit[0], data[0], mem_word(32'h200)); end
    read = 2'b00;
    step;
    $display("stall: 5 cycles on beat 2");
  endtask

  task automatic test_flush;
    req_address[0] = 32'h300; read = 2'b01;
    step;
    mem_ready = 1'b1;
    step;
    checks++; if (mem_address !== 32'h304) begin errors++; $display("FAIL flush_beat1: got %h want 304", mem_address); end
    flush = 1'b1;
    step;
    flush = 1'b0;
    checks++; if (mem_read !== 1'b0 || hit !== 2'b00) begin errors++; $display("FAIL flush_abort: got %b/%b want 0/00", mem_read, hit); end
    req_address[0] = 32'h100;
    step;
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL flush_invalid_hit: got %b want 00", hit); end
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h100) begin errors++; $display("FAIL flush_restart: got %b/%h want 1/100", mem_read, mem_address); end
    wait_refill_done("flush");
    step;
    checks++; if (hit[0] !== 1'b1 || data[0] !== mem_word(32'h100)) begin errors++; $display("FAIL flush_refill_hit: got %b/%h want 1/%h", hit[0], data[0], mem_word(32'h100)); end
    // A flush on a cycle whose lookup would hit suppresses the hit.
    mem_ready = 1'b0;
    flush = 1'b1;
    step;
    flush = 1'b0;
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL flush_no_hit: got %b want 00", hit); end
    step;
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h100) begin errors++; $display("FAIL flush_cleared: got %b/%h want 1/100", mem_read, mem_address); end
    // Flush coinciding with the final beat leaves the line invalid.
    mem_ready = 1'b1;
    step; step; step;
    checks++; if (mem_address !== 32'h10C) begin errors++; $display("FAIL flush_final_addr: got %h want 10C", mem_address); end
    flush = 1'b1;
    step;
    flush = 1'b0;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL flush_final_abort: got %b want 0", mem_read); end
    step;
    checks++; if (hit !== 2'b00 || mem_read !== 1'b1 || mem_address !== 32'h100) begin errors++; $display("FAIL flush_final_invalid: got %b/%b/%h want 00/1/100", hit, mem_read, mem_address); end
    wait_refill_done("flush_final");
    mem_ready = 1'b0;
    read = 2'b00;
    step;
    $display("flush: mid-refill and on final beat");
  endtask

  task automatic test_reset_mid;
    req_address[0] = 32'h500; read = 2'b01;
    step;
    mem_ready = 1'b1;
    step; step;
    checks++; if (mem_address !== 32'h508) begin errors++; $display("FAIL rstmid_beat2: got %h want 508", mem_address); end
    #2 reset = 1'b0;
    #1;
    checks++; if (hit !== 2'b00 || mem_read !== 1'b0 || mem_address !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got %b/%b/%h want 00/0/0", hit, mem_read, mem_address); end
    checks++; if (data[0] !== 32'h0 || address[0] !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h/%h want 0/0", data[0], address[0]); end
`ifdef ICACHE_STATS_EN
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++; $display("FAIL rstmid_stats: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
    mem_ready = 1'b0;
    step;
    reset = 1'b1;
    step;
    checks++; if (hit !== 2'b00 || mem_read !== 1'b1 || mem_address !== 32'h500) begin errors++; $display("FAIL rstmid_invalid: got %b/%b/%h want 00/1/500", hit, mem_read, mem_address); end
    mem_ready = 1'b1;
    wait_refill_done("rstmid");
    mem_ready = 1'b0;
    read = 2'b00;
    step;
    $display("reset_mid: reset on beat 2");
  endtask

  task automatic test_random;
    logic [31:0] resident [int];
    logic [31:0] exp_q [$];
    logic [31:0] a [2];
    logic [1:0]  en;
    logic [1:0]  served;
    logic        bad;
    int          n;
    int          refills = 0;
    int          hits_seen = 0;
    read = 2'b00; flush = 1'b1;
    step;
    flush = 1'b0;
    rand_mode = 1;
    for (int t = 0; t < 60; t++) begin
      ready_pct = $urandom_range(40, 100);
      a[0] = 32'($urandom_range(0, 255)) << 2;
      a[1] = a[0] + 32'd4;
      en = 2'($urandom_range(1, 3));
      exp_q.delete();
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          logic [31:0] line;
          int idx;
          line = a[p] / 16;
          idx = int'(line % 16);
          if (!(resident.exists(idx) && resident[idx] == line)) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(line * 16 + 32'(4 * k));
            resident[idx] = line;
            refills++;
          end
        end
      end
      beat_q.delete();
      req_address[0] = a[0]; req_address[1] = a[1];
      read = en; served = 2'b00; n = 0;
      while (served != en && n < 400) begin
        step;
        n++;
        for (int p = 0; p < 2; p++) begin
          if (read[p] && hit[p]) begin
            checks++; if (data[p] !== mem_word(a[p])) begin errors++; $display("FAIL rnd_data t%0d p%0d: got %h want %h", t, p, data[p], mem_word(a[p])); end
            checks++; if (address[p] !== a[p]) begin errors++; $display("FAIL rnd_address t%0d p%0d: got %h want %h", t, p, address[p], a[p]); end
            served[p] = 1'b1;
            read[p] = 1'b0;
            hits_seen++;
          end
        end
      end
      checks++; if (served !== en) begin errors++; $display("FAIL rnd_timeout t%0d: served %b want %b", t, served, en); end
      bad = (beat_q.size() != exp_q.size());
      if (!bad) for (int k = 0; k < exp_q.size(); k++) if (beat_q[k] !== exp_q[k]) bad = 1'b1;
      checks++; if (bad) begin errors++; $display("FAIL rnd_beats t%0d: got %0d beats want %0d (first want %h)", t, beat_q.size(), exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 32'h0); end
      $display("random t%0d: a=%h en=%b refill_beats=%0d cycles=%0d", t, a[0], en, exp_q.size(), n);
    end
    rand_mode = 0;
    mem_ready = 1'b0;
    read = 2'b00;
    step;
`ifdef ICACHE_STATS_EN
    checks++; if (miss_count !== 32'(refills)) begin errors++; $display("FAIL rnd_miss_count: got %0d want %0d", miss_count, refills); end
    checks++; if (hit_count !== 32'(hits_seen)) begin errors++; $display("FAIL rnd_hit_count: got %0d want %0d", hit_count, hits_seen); end
`endif
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_dual_hit;
    test_split;
    test_stall;
    test_flush;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
